// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the store-and-forward AXI-Stream packet FIFO.
//   drop_reason_t : why the packet on the ingress port is being discarded
//   clog2_min1    : ceil(log2(n)), never less than 1, for index widths
package axis_pkt_pkg;

    typedef enum logic [1:0] {
        DROP_NONE     = 2'd0,
        DROP_USER     = 2'd1,
        DROP_FULL     = 2'd2,
        DROP_PKTLIMIT = 2'd3
    } drop_reason_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_packet_fifo_sf_if.sv
// AXI-Stream bus bundle used on both sides of the packet FIFO.
// Handshake: a beat transfers on a rising clk edge where tvalid and tready
// are both 1; the master holds tdata/tkeep/tuser/tlast stable and keeps
// tvalid high until that edge.
//   master modport : drives payload + tvalid, receives tready
//   slave  modport : receives payload + tvalid, drives tready
interface axis_packet_fifo_sf_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1
);
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic                     tlast;
    logic                     tvalid;
    logic                     tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_packet_fifo_sf_bram.sv
// Simple dual-port RAM, one write port and one read port with 1-cycle
// registered read latency.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
// Addresses are FIFO pointers carrying a lap bit in the MSB; only the low
// ADDR_WIDTH-1 bits select a word, so the array holds 2**(ADDR_WIDTH-1) words.
module axis_packet_fifo_sf_bram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int IW = ADDR_WIDTH - 1;

    logic [DATA_WIDTH-1:0] mem [2**IW];
    logic                  lap_unused;

    assign lap_unused = waddr[ADDR_WIDTH-1] ^ raddr[ADDR_WIDTH-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr[IW-1:0]] <= wdata;
        if (re) rdata <= mem[raddr[IW-1:0]];
    end
endmodule

// File: rtl/axis_packet_fifo_sf.sv
// Store-and-forward AXI-Stream packet FIFO. Beats are written as they
// arrive; a packet becomes visible downstream only once its tlast beat is
// accepted without a drop (commit). A dropped packet rolls the write pointer
// back to the last commit point, so partial data never leaks out.
//   clk, resetn          : clock, async active-low reset
//   s_axis (slave)       : ingress stream, tready is always 1
//   s_axis_tdrop         : ingress request to drop the current packet
//   s_axis_tdropped      : current packet is being dropped (read on tlast)
//   s_drop_reason        : first cause of the drop, valid with tdropped
//   m_axis (master)      : egress stream, first-word-fall-through
//   fill_level           : words in RAM, committed plus in-progress
//   pkt_count            : committed packets whose tlast has not left yet
//   drop_count/commit_count : saturating statistics
module axis_packet_fifo_sf
    import axis_pkt_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int DEPTH       = 64,
    parameter int MAX_PKTS    = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    axis_packet_fifo_sf_if.slave      s_axis,
    input  logic                      s_axis_tdrop,
    output logic                      s_axis_tdropped,
    output drop_reason_t              s_drop_reason,
    axis_packet_fifo_sf_if.master     m_axis,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic [$clog2(MAX_PKTS):0] pkt_count,
    output logic [CNT_WIDTH-1:0]      drop_count,
    output logic [CNT_WIDTH-1:0]      commit_count
);
    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int AW     = clog2_min1(DEPTH);
    localparam int PW     = AW + 1;
    localparam int PCW    = $clog2(MAX_PKTS) + 1;
    localparam int WORD_W = TDATA_WIDTH + KEEP_W + TUSER_WIDTH + 1;
    localparam logic [PW-1:0]        DEPTH_P    = PW'(DEPTH);
    localparam logic [PW-1:0]        PTR_ONE    = PW'(1);
    localparam logic [PCW-1:0]       MAX_PKTS_P = PCW'(MAX_PKTS);
    localparam logic [PCW-1:0]       PCNT_ONE   = PCW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("axis_packet_fifo_sf: DEPTH must be a power of 2 and >= 4");
    end
    if (MAX_PKTS < 1) begin : g_pkts_check
        $error("axis_packet_fifo_sf: MAX_PKTS must be >= 1");
    end

    // ---------------- ingress ----------------
    logic [PW-1:0]  wptr, commit_wptr, rptr;
    logic           drop_seen;
    drop_reason_t   reason_q, cur_reason;
    logic [PCW-1:0] pkt_cnt;
    logic           full, pkt_limit, dropping, beat, wr_en, commit, abort;
    logic           eg_last;

    assign s_axis.tready = 1'b1;
    assign beat      = s_axis.tvalid;
    // A read in this cycle does not relieve full: registered pointers only.
    assign full      = (wptr - rptr) == DEPTH_P;
    assign pkt_limit = s_axis.tlast && (pkt_cnt == MAX_PKTS_P);
    assign dropping  = s_axis_tdrop || full || drop_seen || pkt_limit;
    assign wr_en     = beat && !dropping;
    assign commit    = beat && s_axis.tlast && !dropping;
    assign abort     = beat && s_axis.tlast && dropping;

    // Once a packet is marked, its first cause stays the reported reason.
    always_comb begin
        cur_reason = DROP_NONE;
        if (drop_seen)         cur_reason = reason_q;
        else if (s_axis_tdrop) cur_reason = DROP_USER;
        else if (full)         cur_reason = DROP_FULL;
        else if (pkt_limit)    cur_reason = DROP_PKTLIMIT;
    end

    assign s_axis_tdropped = dropping;
    assign s_drop_reason   = cur_reason;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr         <= '0;
            commit_wptr  <= '0;
            drop_seen    <= 1'b0;
            reason_q     <= DROP_NONE;
            drop_count   <= '0;
            commit_count <= '0;
        end else if (beat) begin
            if (s_axis.tlast) begin
                drop_seen <= 1'b0;
                reason_q  <= DROP_NONE;
            end else if (dropping) begin
                drop_seen <= 1'b1;
                reason_q  <= cur_reason;
            end
            if (abort)      wptr <= commit_wptr;
            else if (wr_en) wptr <= wptr + PTR_ONE;
            if (commit) commit_wptr <= wptr + PTR_ONE;
            if (abort && drop_count != '1)    drop_count   <= drop_count + CNT_ONE;
            if (commit && commit_count != '1) commit_count <= commit_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt <= '0;
        end else begin
            case ({commit, eg_last})
                2'b10:   pkt_cnt <= pkt_cnt + PCNT_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - PCNT_ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // ---------------- storage ----------------
    logic [WORD_W-1:0] rd_word;
    logic              rd_en;

    axis_packet_fifo_sf_bram #(
        .DATA_WIDTH (WORD_W),
        .ADDR_WIDTH (PW)
    ) u_bram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr),
        .wdata ({s_axis.tlast, s_axis.tuser, s_axis.tkeep, s_axis.tdata}),
        .re    (rd_en),
        .raddr (rptr),
        .rdata (rd_word)
    );

    // ---------------- egress skid ----------------
    // e0 is the presented word, e1 the overflow slot. A read is issued only
    // if, after this cycle's pop, the skid plus the in-flight read leaves a
    // free slot for it; counting the pop keeps 1 beat/clk streaming.
    logic [WORD_W-1:0] e0, e1;
    logic              v0, v1, rd_pend, pop;
    logic [1:0]        occ_np;

    assign pop     = v0 && m_axis.tready;
    assign eg_last = pop && e0[WORD_W-1];
    assign occ_np  = {1'b0, v0} + {1'b0, v1} + {1'b0, rd_pend} - {1'b0, pop};
    assign rd_en   = (rptr != commit_wptr) && (occ_np < 2'd2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rptr    <= '0;
            rd_pend <= 1'b0;
            e0      <= '0;
            e1      <= '0;
            v0      <= 1'b0;
            v1      <= 1'b0;
        end else begin
            if (rd_en) rptr <= rptr + PTR_ONE;
            rd_pend <= rd_en;
            case ({pop, rd_pend})
                2'b11: begin
                    if (v1) begin
                        e0 <= e1;
                        e1 <= rd_word;
                    end else begin
                        e0 <= rd_word;
                    end
                end
                2'b10: begin
                    e0 <= e1;
                    v0 <= v1;
                    v1 <= 1'b0;
                end
                2'b01: begin
                    if (!v0) begin
                        e0 <= rd_word;
                        v0 <= 1'b1;
                    end else begin
                        e1 <= rd_word;
                        v1 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis.tvalid = v0;
    assign {m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata} = e0;

    assign fill_level = wptr - rptr;
    assign pkt_count  = pkt_cnt;
endmodule

// File: doc/axis_packet_fifo_sf.md
Name: axis_packet_fifo_sf

Overview:
Store-and-forward AXI-Stream packet FIFO with tkeep/tuser sideband, a packet-count limit, a registered first-word-fall-through output and drop statistics. Packets are committed atomically on an accepted, non-dropped tlast beat. Only committed packets are ever presented downstream. Sits between ingress parsers and the router arbiter, with one instance per ingress port.

Parameters:
TDATA_WIDTH, 32, data width in bits (multiple of 8)
TUSER_WIDTH, 1, tuser width; sampled per beat, stored with the beat
DEPTH, 64, word capacity; power of 2, >=4 (elaboration $error otherwise)
MAX_PKTS, 16, maximum committed packets resident; >=1
CNT_WIDTH, 32, width of the saturating statistics counters

Ports:
clk  in  1  clock
resetn  in  1  reset
s_axis_tdata  in  TDATA_WIDTH  ingress data
s_axis_tkeep  in  TDATA_WIDTH/8  byte enables
s_axis_tuser  in  TUSER_WIDTH  sideband
s_axis_tlast  in  1  end of packet
s_axis_tdrop  in  1  request drop of current packet (any beat)
s_axis_tvalid  in  1  ingress valid
s_axis_tready  out  1  constant 1
s_axis_tdropped  out  1  current packet is being dropped; meaningful on accepted tlast beat
s_drop_reason  out  2  drop_reason_t, valid with s_axis_tdropped
m_axis_tdata  out  TDATA_WIDTH  egress data
m_axis_tkeep  out  TDATA_WIDTH/8  egress byte enables
m_axis_tuser  out  TUSER_WIDTH  egress sideband
m_axis_tlast  out  1  egress end of packet
m_axis_tvalid  out  1  egress valid
m_axis_tready  in  1  egress ready
fill_level  out  $clog2(DEPTH)+1  words resident, committed plus in-progress
pkt_count  out  $clog2(MAX_PKTS)+1  committed packets not yet fully read
drop_count  out  CNT_WIDTH  saturating count of dropped packets
commit_count  out  CNT_WIDTH  saturating count of committed packets

Behaviour:
- Reset (clk, resetn): async assert, active-low; sync deassert handled upstream. All pointers, counters and m_axis_tvalid reset to 0; drop_reason resets to DROP_NONE. Asserting reset mid-packet discards all content, committed or partial.
- Pointers: wptr, commit_wptr and rptr are $clog2(DEPTH)+1 bits wide; extra MSB wraps.
  - full: (wptr - rptr) == DEPTH, evaluated on registered values.
  - A read in the same cycle does not relieve full; the beat is still dropped.
- Drop state is sticky per packet: drop_seen sets on an accepted beat with tdrop=1 or full=1 and clears on an accepted tlast beat.
- Drop reason is decided on the tlast beat. dropping = tdrop | full | drop_seen | (tlast & pkt_count==MAX_PKTS). Priority is DROP_USER > DROP_FULL > DROP_PKTLIMIT, latched on the first cause seen.
- Accepted beat, not dropping: write {tlast,tuser,tkeep,tdata}; wptr+1.
- Accepted tlast, not dropping: commit_wptr <= wptr+1; pkt_count+1; commit_count+1.
- Accepted tlast, dropping: wptr <= commit_wptr; drop_count+1; no partial word is ever visible downstream.
- Single-beat packet with tdrop=1: nothing written; drop_count+1.
- Output path: bram sub-module with 1-cycle read latency, plus a 2-entry output skid register.
  - Reads are issued only while rptr != commit_wptr.
  - The first beat of a committed packet appears on m_axis_tvalid 2 cycles after the commit edge.
  - Sustained 1 beat/clk while m_axis_tready=1.
  - m_axis_* are held stable while tvalid & !tready.
- pkt_count decrements on the egress handshake with tlast=1. Commit and egress tlast in the same cycle leave it unchanged.
- fill_level = wptr - rptr, where rptr counts words handed to the skid stage. Words held in the skid are not counted.
- Statistics counters saturate at all-ones and never wrap.

Decomposition:
- Package axis_pkt_pkg:
  - typedef enum logic [1:0] drop_reason_t {DROP_NONE, DROP_USER, DROP_FULL, DROP_PKTLIMIT}
  - function clog2_min1
- Sub-module: the existing bram (DATA_WIDTH = TDATA_WIDTH + TDATA_WIDTH/8 + TUSER_WIDTH + 1, ADDR_WIDTH = $clog2(DEPTH)+1).
- The output skid is inline, not a separate module.

Test Plan:
1. DEPTH=16. Send 3-beat packet 0xA0..0xA2, tkeep=F on all beats, m_axis_tready=1 -> m_axis_tvalid rises 2 clk after tlast edge; beats 0xA0,0xA1,0xA2 on consecutive clk; tlast on 0xA2; commit_count=1.
2. 5-beat packet with tdrop=1 on beat 2 only -> s_axis_tdropped=1 and s_drop_reason=DROP_USER on tlast; m_axis_tvalid never asserts; drop_count=1; fill_level returns to 0.
3. DEPTH=16, m_axis_tready=0. Send 20-beat packet -> s_drop_reason=DROP_FULL; nothing emitted. A following 4-beat packet is committed and emitted intact.
4. MAX_PKTS=2, m_axis_tready=0. Send three 1-beat packets -> third dropped with DROP_PKTLIMIT; pkt_count=2. Release tready -> exactly 2 beats out, pkt_count=0.
5. Back-to-back 8-beat packets, tready toggled 1/0 every clk -> no beat lost or duplicated; m_axis_* stable while stalled. Runs across pointer wrap (≥3×DEPTH beats).
6. Assert resetn=0 mid-packet with one committed packet resident -> m_axis_tvalid=0 immediately; all counters 0. A fresh packet after reset passes intact.
